mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Shares the single main-memory bus slot between up to four requesters: video fetch, DSP, blitter and CPU.
- Sequences each access: grant, a configurable wait-state count, a done strobe, then a one-cycle bus turnaround.
- Sits between the requester bus masters and the memory-decode macros (wide AND address decode, strobes). Its one-hot grant vector gates which master drives the address and strobes.

Parameters:
- NREQ, 4, number of requesters; index 0 has highest fixed priority.
- WAIT_W, 3, width of the wait-state count.

Ports:
- CLOCK  input  1  system clock, rising-edge active.
- RESETL  input  1  asynchronous active-low reset.
- REQ  input  NREQ  per-requester access request, level, held until DONE.
- LOCK  input  NREQ  per-requester bus-lock; keeps ownership for back-to-back accesses.
- WAITS  input  WAIT_W  wait states per access; sampled when an access starts.
- GNT  output  NREQ  one-hot grant, registered.
- OWNER  output  log2(NREQ)  index of the current/last owner, registered.
- BUSY  output  1  high while any GNT bit is high.
- DONE  output  1  one-cycle strobe in the final cycle of an access.

Behaviour:
- Interface: one clock (CLOCK). Reset RESETL is asynchronous and active-low. Everything else is synchronous to the CLOCK rising edge.
- Reset values: GNT=0, OWNER=0, BUSY=0, DONE=0, state=IDLE, counter=0. Reset asserted mid-access clears GNT and DONE immediately, without waiting for a clock edge. After reset release, arbitration restarts from IDLE.
- States: IDLE, ACCESS, TURN.
- IDLE and TURN:
  - GNT=0.
  - At the clock edge, if any REQ bit is set, the winner is the lowest set index (fixed priority).
  - The winner goes to ACCESS: GNT=onehot(winner), OWNER=winner, counter loaded with WAITS.
  - Grant latency is 1 edge: a REQ sampled at edge k gives GNT visible after edge k.
- TURN: always a 1-cycle dead bus. TURN goes to IDLE if no request is present; otherwise it grants directly.
- ACCESS:
  - GNT is held.
  - If counter != 0, decrement the counter.
  - If counter == 0, DONE=1 in this cycle (combinational from the registered state).
  - At the edge ending that cycle:
    - If LOCK[OWNER] and REQ[OWNER] are both set, stay in ACCESS, reload the counter from WAITS, and assert no TURN.
    - Otherwise go to TURN.
- Access length: WAITS+1 cycles with GNT high. WAITS=0 gives a single-cycle access with DONE in that first cycle.
- REQ dropped mid-access: the access still completes to DONE (no abort). The owner's REQ is ignored until DONE.
- WAITS changes mid-access have no effect on the access in progress.
- Simultaneous requests: exactly one grant. Losers wait.
- Starvation: losers can starve under fixed priority while a higher requester keeps requesting. LOCK extends this; requesters must bound LOCK use.
- Counter arithmetic: unsigned, WAIT_W bits, never wraps (decrements only from a nonzero value).
- Invariant: GNT is always zero or one-hot. BUSY = |GNT.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - Index 0 keeps absolute priority.
  - Indices 1..NREQ-1 arbitrate round-robin: search starts at the index after the last granted index in that group and wraps from NREQ-1 back to 1.
  - The rotation pointer resets to 1 and updates only when a grant to the group is issued.
- Undefined: pure fixed priority as above; no pointer register exists.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the state enum (IDLE, ACCESS, TURN);
  - requester index constants (REQ_VIDEO=0, REQ_DSP=1, REQ_BLIT=2, REQ_CPU=3);
  - the default WAIT_W.
- One sub-module, mem_arb_pick: purely combinational priority/round-robin picker. It takes the REQ vector and pointer and returns a valid flag and the winner index. It is reused for the round-robin variant.

Test Plan:
- Reset: hold RESETL=0 with REQ=4'b1111 -> GNT=0, BUSY=0, DONE=0. Assert RESETL=0 mid-ACCESS -> GNT=0 before the next edge.
- Single request: REQ=4'b1000, WAITS=2 -> GNT=4'b1000 after 1 edge, high 3 cycles, DONE in the 3rd. Then 1 cycle GNT=0, and re-grant if REQ is still high.
- Simultaneous: REQ=4'b1110, WAITS=0 -> grant order 1, 2, 3, each a 1-cycle access separated by a TURN cycle. OWNER=1,2,3.
- Priority pre-emption at boundary: CPU (3) in ACCESS with WAITS=3; video REQ[0] raised mid-access -> CPU completes 4 cycles, then TURN, then GNT=4'b0001.
- Lock: REQ[2]=LOCK[2]=1, WAITS=1, REQ[0] raised -> blitter gets back-to-back 2-cycle accesses with no TURN. Drop LOCK[2] -> after the current DONE, TURN, then video granted.
- ARB_ROUND_ROBIN_EN: REQ=4'b1110 held constantly, WAITS=0 -> grant sequence 1,2,3,1,2,3. With the macro undefined -> 1,1,1....

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, requester indices and default widths for the memory bus arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, TURN = 2'd2} arb_state_t;
  localparam int REQ_VIDEO = 0;
  localparam int REQ_DSP = 1;
  localparam int REQ_BLIT = 2;
  localparam int REQ_CPU = 3;
  localparam int NREQ_DEF = 4;
  localparam int WAIT_W_DEF = 3;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner picker; index 0 always wins, others are searched from i_ptr wrapping within 1..NREQ-1
module mem_arb_pick #(
  parameter int NREQ = 4,
  parameter int IW = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic            o_valid,
  output logic [IW-1:0]   o_idx
);
  // Walk the search order backwards so the earliest candidate in that order is the last one written
  always_comb begin
    o_valid = |i_req;
    o_idx = '0;
    for (int k = NREQ - 2; k >= 0; k--)
      if (i_req[1 + (int'(i_ptr) - 1 + k) % (NREQ - 1)]) o_idx = IW'(1 + (int'(i_ptr) - 1 + k) % (NREQ - 1));
    if (i_req[0]) o_idx = '0;
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: grants the memory bus slot, runs wait states, strobes DONE, then a one-cycle turnaround; ARB_ROUND_ROBIN_EN rotates indices 1..NREQ-1
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int WAIT_W = WAIT_W_DEF
) (
  input  logic                    CLOCK,
  input  logic                    RESETL,
  input  logic [NREQ-1:0]         REQ,
  input  logic [NREQ-1:0]         LOCK,
  input  logic [WAIT_W-1:0]       WAITS,
  output logic [NREQ-1:0]         GNT,
  output logic [$clog2(NREQ)-1:0] OWNER,
  output logic                    BUSY,
  output logic                    DONE
);
  localparam int IW = $clog2(NREQ);
  arb_state_t        r_state;
  logic [WAIT_W-1:0] r_cnt;
  logic [NREQ-1:0]   r_gnt;
  logic [IW-1:0]     r_owner;
  logic [IW-1:0]     w_ptr;
  logic              w_valid;
  logic [IW-1:0]     w_idx;
  logic              w_keep;
  logic              w_done;
  assign w_done = (r_state == ACCESS) && (r_cnt == '0);
  assign w_keep = LOCK[r_owner] & REQ[r_owner];
  assign GNT = r_gnt;
  assign OWNER = r_owner;
  assign BUSY = |r_gnt;
  assign DONE = w_done;
  mem_arb_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .i_req   (REQ),
    .i_ptr   (w_ptr),
    .o_valid (w_valid),
    .o_idx   (w_idx)
  );
`ifdef ARB_ROUND_ROBIN_EN
  logic [IW-1:0] r_ptr;
  assign w_ptr = r_ptr;
  // Advance the rotation pointer past the winner whenever a grant goes to the rotating group
  always_ff @(posedge CLOCK or negedge RESETL) begin
    if (!RESETL) r_ptr <= IW'(1);
    else if (r_state != ACCESS && w_valid && w_idx != '0)
      r_ptr <= (w_idx == IW'(NREQ - 1)) ? IW'(1) : w_idx + IW'(1);
  end
`else
  assign w_ptr = IW'(1);
`endif
  // Access sequencer: arbitrate in IDLE/TURN, count wait states in ACCESS, then hold for lock or turn around
  always_ff @(posedge CLOCK or negedge RESETL) begin
    if (!RESETL) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_gnt <= '0;
      r_owner <= '0;
    end else if (r_state == ACCESS) begin
      if (r_cnt != '0) r_cnt <= r_cnt - WAIT_W'(1);
      else if (w_keep) r_cnt <= WAITS;
      else begin
        r_state <= TURN;
        r_gnt <= '0;
      end
    end else if (w_valid) begin
      r_state <= ACCESS;
      r_gnt <= NREQ'(1) << w_idx;
      r_owner <= w_idx;
      r_cnt <= WAITS;
    end else begin
      r_state <= IDLE;
      r_gnt <= '0;
    end
  end
endmodule
